mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu.sv | 116 +++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared CPU definitions: MDU operation encodings, default latencies and
// the MDU control states.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic isMulDiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. Operands are latched on accept and
// the behavioural result is committed to HI/LO when the latency counter expires.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  output logic [31:0] E_MDUO,
  output logic        Start,
  output logic        Busy
);

  localparam int MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CntW   = $clog2(MaxLat + 1);

  mdu_state_e      stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic [31:0]     aQ, aD, bQ, bD;
  logic [3:0]      opQ, opD;
  logic [31:0]     hiQ, hiD, loQ, loD;
  logic            accept;

  logic [63:0]     mulA, mulB, product;
  logic            signedDiv;
  logic [31:0]     aMag, bMag, quoMag, remMag, quo, rem;

  // Arithmetic on the latched operands; signed division works on magnitudes so
  // the most-negative dividend never overflows.
  always_comb begin
    mulA      = (opQ == MDU_MULT) ? {{32{aQ[31]}}, aQ} : {32'b0, aQ};
    mulB      = (opQ == MDU_MULT) ? {{32{bQ[31]}}, bQ} : {32'b0, bQ};
    product   = mulA * mulB;
    signedDiv = (opQ == MDU_DIV);
    aMag      = (signedDiv && aQ[31]) ? -aQ : aQ;
    bMag      = (signedDiv && bQ[31]) ? -bQ : bQ;
    quoMag    = (bMag != 32'd0) ? (aMag / bMag) : 32'd0;
    remMag    = (bMag != 32'd0) ? (aMag % bMag) : 32'd0;
    quo       = (signedDiv && (aQ[31] ^ bQ[31])) ? -quoMag : quoMag;
    rem       = (signedDiv && aQ[31]) ? -remMag : remMag;
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    aD     = aQ;
    bD     = bQ;
    opD    = opQ;
    hiD    = hiQ;
    loD    = loQ;
    accept = 1'b0;
    case (stateQ)
      S_IDLE: begin
        if (isMulDiv(E_MDUOp)) begin
          accept = 1'b1;
          aD     = E_rs;
          bD     = E_rt;
          opD    = E_MDUOp;
          cntD   = ((E_MDUOp == MDU_MULT) || (E_MDUOp == MDU_MULTU)) ?
                   CntW'(MULT_LAT) : CntW'(DIV_LAT);
          stateD = S_RUN;
        end else if (E_MDUOp == MDU_MTHI) begin
          hiD = E_rs;
        end else if (E_MDUOp == MDU_MTLO) begin
          loD = E_rs;
        end
      end
      S_RUN: begin
        cntD = cntQ - CntW'(1);
        if (cntQ == CntW'(1)) begin
          stateD = S_IDLE;
          if ((opQ == MDU_MULT) || (opQ == MDU_MULTU)) begin
            hiD = product[63:32];
            loD = product[31:0];
          end else if (bQ != 32'd0) begin
            hiD = rem;
            loD = quo;
          end
        end
      end
      default: stateD = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= S_IDLE;
      cntQ   <= '0;
      aQ     <= '0;
      bQ     <= '0;
      opQ    <= '0;
      hiQ    <= '0;
      loQ    <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      aQ     <= aD;
      bQ     <= bD;
      opQ    <= opD;
      hiQ    <= hiD;
      loQ    <= loD;
    end
  end

  assign Busy   = (stateQ == S_RUN);
  assign Start  = accept && !rst;
  assign E_MDUO = rst                   ? 32'd0 :
                  (E_MDUOp == MDU_MFHI) ? hiQ   :
                  (E_MDUOp == MDU_MFLO) ? loQ   : 32'd0;

endmodule
